// File: rtl/bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_pkg
// Description : Shared constants and types for the five-digit BCD
//               seven-segment scanner: the digit count, active-low segment
//               patterns and the digit index type.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_display_pkg;

    localparam int NUM_DIGITS = 5;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Index 0..9 holds the pattern for that decimal digit.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef logic [2:0] digit_idx_t;

endpackage : bcd_display_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational decoder from one BCD nibble to active-low
//               seven-segment pattern. Nibbles A-F show a dash; blank forces
//               every segment dark.
// Ports       : nibble - BCD digit to decode
//               blank  - 1 = force all segments off
//               seg    - {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (nibble <= 4'd9) begin
            seg = SEG_TABLE[nibble];
        end else begin
            seg = SEG_DASH;
        end
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scanner
// Description : Latches a five-digit packed BCD value and scans it onto a
//               common-anode multiplexed seven-segment display, one digit per
//               REFRESH_DIV clocks, with optional leading-zero blanking.
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous active-high reset
//               load     - capture bcd_in at this edge
//               bcd_in   - packed BCD, [3:0] = units
//               blank_lz - 1 = blank leading zeros
//               an       - anode enables, active-low one-hot, an[0] = units
//               seg      - {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [19:0] bcd_in,
    input  logic        blank_lz,
    output logic [4:0]  an,
    output logic [6:0]  seg
);

    // A one-cycle refresh still needs a one-bit counter to keep widths legal.
    localparam int                 c_pre_w   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(REFRESH_DIV - 1);
    localparam digit_idx_t         c_idx_max = digit_idx_t'(NUM_DIGITS - 1);

    logic [c_pre_w-1:0]      r_prescaler;
    digit_idx_t              r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4:0]              r_an;
    logic [6:0]              r_seg;

    logic                    w_tick;
    logic [3:0]              w_nibble;
    logic [NUM_DIGITS-1:0]   w_zero_up;
    logic                    w_blank;
    logic [4:0]              w_an;
    logic [6:0]              w_seg;

    assign w_tick = (r_prescaler == c_pre_max);

    // w_zero_up[i] is set when digit i and every digit above it are zero.
    always_comb begin
        logic v_acc;
        v_acc     = 1'b1;
        w_zero_up = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_acc        = v_acc & (r_disp[4*i +: 4] == 4'd0);
            w_zero_up[i] = v_acc;
        end
    end

    always_comb begin
        w_nibble = r_disp[3:0];
        case (r_idx)
            3'd0:    w_nibble = r_disp[3:0];
            3'd1:    w_nibble = r_disp[7:4];
            3'd2:    w_nibble = r_disp[11:8];
            3'd3:    w_nibble = r_disp[15:12];
            default: w_nibble = r_disp[19:16];
        endcase
    end

    // The units digit is never blanked so a zero value still reads "0".
    assign w_blank = blank_lz && (r_idx != 3'd0) && w_zero_up[r_idx];
    assign w_an    = ~(5'b00001 << r_idx);

    bcd_to_seg7 u_dec (
        .nibble (w_nibble),
        .blank  (w_blank),
        .seg    (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler <= '0;
            r_idx       <= '0;
            r_disp      <= '0;
            r_an        <= 5'b11111;
            r_seg       <= SEG_BLANK;
        end else begin
            if (load) begin
                r_disp <= bcd_in;
            end

            if (w_tick) begin
                r_prescaler <= '0;
                r_idx       <= (r_idx == c_idx_max) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end

            // Outputs reflect the idx/disp values held before this edge.
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule : bcd_display_scanner
`default_nettype wire
